// File: rtl/br_write_arbiter.sv
// ----------------------------------------------------------------------------
// br_write_arbiter : round-robin arbiter sharing the register-bank write port
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module br_write_arbiter #(
  parameter int NREQ         = 2,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int CW           = 16,
  parameter int ZERO_DISCARD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_dir,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic               RegEn,
  output logic [AW-1:0]      Dir,
  output logic [DW-1:0]      Di,
  output logic               fwd_valid,
  output logic [CW-1:0]      conflicts
);

  localparam int c_PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            r_ob_valid;
  logic [AW-1:0]   r_dir;
  logic [DW-1:0]   r_di;
  logic [c_PW-1:0] r_ptr;
  logic [CW-1:0]   r_conflicts;

  logic            w_ld;
  logic            w_commit;
  logic            w_found;
  logic            w_xfer;
  logic            w_zero;
  logic            w_multi;
  logic [NREQ-1:0] w_grant;
  logic [c_PW-1:0] w_gidx;
  logic [c_PW-1:0] w_ptr_nxt;
  logic [AW-1:0]   w_sel_dir;
  logic [DW-1:0]   w_sel_data;

  // The buffer can take a new entry whenever it is empty or draining this cycle.
  assign w_commit = r_ob_valid & ~hold;
  assign w_ld     = ~r_ob_valid | ~hold;

  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found      = 1'b1;
        w_grant[idx] = 1'b1;
        w_gidx       = c_PW'(idx);
      end
    end
  end

  assign req_ready  = w_ld ? w_grant : '0;
  assign w_xfer     = w_ld & w_found;
  assign w_sel_dir  = req_dir[w_gidx*AW +: AW];
  assign w_sel_data = req_data[w_gidx*DW +: DW];
  assign w_zero     = (ZERO_DISCARD != 0) && (w_sel_dir == '0);
  assign w_ptr_nxt  = (w_gidx == c_PW'(NREQ-1)) ? '0 : w_gidx + 1'b1;
  assign w_multi    = ($countones(req_valid) >= 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ob_valid  <= 1'b0;
      r_dir       <= '0;
      r_di        <= '0;
      r_ptr       <= '0;
      r_conflicts <= '0;
    end else begin
      if (w_xfer) begin
        r_ptr <= w_ptr_nxt;
        if (!w_zero) begin
          r_ob_valid <= 1'b1;
          r_dir      <= w_sel_dir;
          r_di       <= w_sel_data;
        end else if (w_commit) begin
          r_ob_valid <= 1'b0;
        end
      end else if (w_commit) begin
        r_ob_valid <= 1'b0;
      end
      if (w_multi && (r_conflicts != '1)) begin
        r_conflicts <= r_conflicts + 1'b1;
      end
    end
  end

  assign RegEn     = w_commit;
  assign Dir       = r_dir;
  assign Di        = r_di;
  assign fwd_valid = r_ob_valid;
  assign conflicts = r_conflicts;

endmodule

`default_nettype wire

// File: tb/tb_br_write_arbiter.sv
// Scoreboard bench for br_write_arbiter: randomized and directed traffic vs. a reference model.
`default_nettype none

module tb_br_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    a_valid;
  logic [N*AW-1:0] a_dir;
  logic [N*DW-1:0] a_data;
  logic [N-1:0]    a_ready;
  logic            a_hold;
  logic            a_regen;
  logic [AW-1:0]   a_dir_o;
  logic [DW-1:0]   a_di;
  logic            a_fwd;
  logic [15:0]     a_conf;

  logic [1:0]      b_valid;
  logic [2*AW-1:0] b_dir;
  logic [2*DW-1:0] b_data;
  logic [1:0]      b_ready;
  logic            b_hold;
  logic            b_regen;
  logic [AW-1:0]   b_dir_o;
  logic [DW-1:0]   b_di;
  logic            b_fwd;
  logic [1:0]      b_conf;

  br_write_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .CW(16), .ZERO_DISCARD(1)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_dir(a_dir), .req_data(a_data),
    .req_ready(a_ready), .hold(a_hold), .RegEn(a_regen), .Dir(a_dir_o), .Di(a_di),
    .fwd_valid(a_fwd), .conflicts(a_conf));

  br_write_arbiter #(.NREQ(2), .AW(AW), .DW(DW), .CW(2), .ZERO_DISCARD(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_dir(b_dir), .req_data(b_data),
    .req_ready(b_ready), .hold(b_hold), .RegEn(b_regen), .Dir(b_dir_o), .Di(b_di),
    .fwd_valid(b_fwd), .conflicts(b_conf));

  int total = 0;
  int bad   = 0;

  // Reference model: requester intent, buffer occupancy, pointer, expected commit stream.
  bit            rv[N];
  logic [AW-1:0] rd[N];
  logic [DW-1:0] rdat[N];
  bit            hb;
  int            m_ptr;
  int            m_conf;
  bit            m_pend;
  int            acc;
  bit            mon_en;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [AW+DW-1:0] e;
    if (mon_en && a_regen === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL commit: got write Dir=%0h Di=%0h expected no write", a_dir_o, a_di);
      end else begin
        e = exp_q.pop_front();
        check("commit", {a_dir_o, a_di}, e);
      end
    end
  end

  // One clock of traffic on instance A: drive, predict, compare, advance model.
  task automatic cyc();
    int g;
    int idx;
    int pc;
    bit ld;
    bit ren;
    logic [N-1:0] er;
    for (int i = 0; i < N; i++) begin
      a_valid[i]          = rv[i];
      a_dir[i*AW +: AW]   = rd[i];
      a_data[i*DW +: DW]  = rdat[i];
    end
    a_hold = hb;
    ren = m_pend && !hb;
    ld  = !m_pend || !hb;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && rv[idx]) g = idx;
    end
    er = '0;
    if (ld && g >= 0) er[g] = 1'b1;
    @(negedge clk);
    check("req_ready", a_ready, er);
    check("RegEn", a_regen, ren);
    check("fwd_valid", a_fwd, m_pend);
    check("conflicts", a_conf, m_conf);
    if (m_pend && hb && exp_q.size() > 0) check("fwd_data", {a_dir_o, a_di}, exp_q[0]);
    @(posedge clk);
    pc = 0;
    for (int i = 0; i < N; i++) pc += rv[i] ? 1 : 0;
    if (pc >= 2 && m_conf < 65535) m_conf++;
    acc = -1;
    if (ld && g >= 0) begin
      acc   = g;
      m_ptr = (g + 1) % N;
      if (rd[g] != 0) begin
        exp_q.push_back({rd[g], rdat[g]});
        m_pend = 1'b1;
      end else if (ren) begin
        m_pend = 1'b0;
      end
    end else if (ren) begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic newreq(input int i);
    rv[i]   = ($urandom_range(0, 3) != 0);
    rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    rdat[i] = $urandom;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) rv[i] = 1'b0;
  endtask

  int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst_n  = 1'b0;
    mon_en = 1'b1;
    a_valid = '0; a_dir = '0; a_data = '0; a_hold = 1'b0;
    b_valid = '0; b_dir = '0; b_data = '0; b_hold = 1'b0;
    for (int i = 0; i < N; i++) begin rv[i] = 0; rd[i] = '0; rdat[i] = '0; end
    hb = 0; m_ptr = 0; m_conf = 0; m_pend = 0; acc = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_RegEn", a_regen, 0);
    check("rst_Dir", a_dir_o, 0);
    check("rst_Di", a_di, 0);
    check("rst_fwd", a_fwd, 0);
    check("rst_conf", a_conf, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while a held write sits in the buffer.
    rv[0] = 1; rd[0] = 5'd7; rdat[0] = 32'hDEADBEEF; hb = 1;
    cyc();
    rv[0] = 0;
    cyc();
    rst_n = 1'b0;
    #1;
    check("rstmid_RegEn", a_regen, 0);
    check("rstmid_Dir", a_dir_o, 0);
    check("rstmid_Di", a_di, 0);
    check("rstmid_fwd", a_fwd, 0);
    exp_q.delete();
    m_pend = 0; m_ptr = 0; m_conf = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester, one-cycle latency.
    hb = 0;
    rv[0] = 1; rd[0] = 5'd3; rdat[0] = 32'h11;
    cyc();
    rv[0] = 0;
    cyc();
    cyc();

    // Two requesters held valid alternate at full throughput.
    rv[0] = 1; rd[0] = 5'd1; rdat[0] = 32'hA;
    rv[1] = 1; rd[1] = 5'd2; rdat[1] = 32'hB;
    repeat (4) cyc();
    clear_reqs();
    cyc();
    check("rr_conflicts", a_conf, 4);
    cyc();

    // Hold freezes a loaded buffer.
    rv[0] = 1; rd[0] = 5'd5; rdat[0] = 32'h55;
    cyc();
    rv[0] = 0;
    rv[1] = 1; rd[1] = 5'd9; rdat[1] = 32'h99;
    hb = 1;
    repeat (3) cyc();
    hb = 0;
    cyc();
    rv[1] = 0;
    cyc();
    cyc();

    // Write to register 0 is accepted but discarded.
    rv[0] = 1; rd[0] = 5'd0; rdat[0] = 32'hFF;
    rv[1] = 1; rd[1] = 5'd4; rdat[1] = 32'h44;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (acc >= 0) rv[acc] = 0;
    end
    clear_reqs();
    cyc();

    // Randomized traffic with random stalls.
    for (int c = 0; c < 1500; c++) begin
      hb = ($urandom_range(0, 3) == 0);
      cyc();
      if (acc >= 0) newreq(acc);
      for (int i = 0; i < N; i++)
        if (!rv[i] && $urandom_range(0, 1) == 1) newreq(i);
    end
    clear_reqs();
    hb = 0;
    repeat (3) cyc();
    check("drain_empty", exp_q.size(), 0);

    // Instance B: register 0 is an ordinary target.
    b_valid = 2'b01; b_dir[4:0] = 5'd0; b_data[31:0] = 32'hFF;
    @(negedge clk);
    check("zd0_ready", b_ready, 2'b01);
    check("zd0_RegEn_pre", b_regen, 0);
    @(posedge clk); #1;
    b_valid = 2'b00;
    @(negedge clk);
    check("zd0_RegEn", b_regen, 1);
    check("zd0_Dir", b_dir_o, 0);
    check("zd0_Di", b_di, 32'hFF);
    check("zd0_conf", b_conf, 0);
    @(posedge clk); #1;

    // Instance B: 2-bit conflict counter saturates.
    b_valid = 2'b11; b_dir[4:0] = 5'd1; b_dir[9:5] = 5'd2;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("sat_%0d", c), b_conf, sat_exp[c]);
    end
    #1 b_valid = 2'b00;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/br_write_arbiter.md
Name: br_write_arbiter

Overview:
- Shares the single write port of the register bank (Dir/Di/RegEn) between NREQ writeback requesters, e.g. ALU result and memory load.
- Uses round-robin arbitration and valid/ready handshakes.
- A one-entry output buffer drives the write port and can be held by the pipeline.
- Exposes the buffered write for read-side forwarding, plus a saturating conflict counter for performance monitoring.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.
- CW, 16, conflict counter width.
- ZERO_DISCARD, 1, when 1 writes to register 0 are accepted but never issued.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester write request.
- req_dir  in  NREQ*AW  target register; requester i uses slice [i*AW +: AW].
- req_data  in  NREQ*DW  write data; requester i uses slice [i*DW +: DW].
- req_ready  out  NREQ  per-requester accept (combinational).
- hold  in  1  pipeline stall; freezes the write port.
- RegEn  out  1  register bank write enable.
- Dir  out  AW  register bank write address.
- Di  out  DW  register bank write data.
- fwd_valid  out  1  buffered write pending (not yet committed).
- conflicts  out  CW  saturating count of cycles with two or more requests valid.

Behaviour:
- Reset (async, rst_n=0):
  - ob_valid=0, Dir=0, Di=0, RegEn=0, conflicts=0, round-robin pointer ptr=0.
  - A pending buffered write is dropped and never issued.
- Output buffer (ob_valid, Dir, Di):
  - RegEn = ob_valid & ~hold (combinational).
  - Commit happens on the cycle RegEn=1; the buffer frees at that edge.
- Load enable: ld = ~ob_valid | ~hold. The buffer accepts new data in the same cycle it commits, giving 1 write/cycle throughput.
- Arbitration (combinational):
  - Scan indices ptr, ptr+1, ... mod NREQ; the first with req_valid=1 is granted.
  - req_ready[i] = ld & grant[i]. At most one ready bit is high.
  - No request valid means no grant, and ptr is unchanged.
- Transfer on req_valid[i] & req_ready[i]:
  - At the next edge ptr <= (i+1) mod NREQ.
  - Buffer loads Dir <= req_dir[i], Di <= req_data[i], ob_valid <= 1.
  - Latency: request accepted in cycle N, RegEn high in cycle N+1 if hold=0.
- ZERO_DISCARD=1 and req_dir[i]==0:
  - The transfer completes and ptr advances.
  - The buffer is not loaded: ob_valid <= 0 if it committed this cycle, otherwise unchanged.
  - Dir/Di keep their previous values.
- ZERO_DISCARD=0: register 0 is treated like any other register.
- No transfer and buffer committed: ob_valid <= 0; Dir/Di keep stale values (don't-care while RegEn=0).
- hold=1 with ob_valid=1:
  - RegEn=0 and all req_ready=0.
  - Dir/Di stable; ptr frozen.
- hold=1 with ob_valid=0: one transfer still accepted; it then waits in the buffer.
- fwd_valid = ob_valid. Dir/Di double as forwarding address/data for hazard logic.
- conflicts:
  - Increments when popcount(req_valid) >= 2, regardless of hold.
  - Saturates at 2^CW-1.
- Requesters must hold req_valid/dir/data stable until accepted. The arbiter never depends on ready->valid paths.

Test Plan:
1. Reset mid-write: load dir=7, data=0xDEADBEEF with hold=1; pulse rst_n low -> RegEn never asserts; Dir=0, Di=0, fwd_valid=0 immediately.
2. Single requester: req0 dir=3, data=0x11 in cycle 1 -> req_ready[0]=1 in cycle 1; RegEn=1, Dir=3, Di=0x11 in cycle 2; RegEn=0 in cycle 3.
3. Round-robin: both requesters held valid (r0 dir=1, data=0xA; r1 dir=2, data=0xB) for 4 cycles -> commits alternate 1,2,1,2 at one per cycle; conflicts=4.
4. Hold: buffer holds dir=5, hold=1 for 3 cycles with req1 valid -> RegEn=0 and req_ready=0 for 3 cycles; fwd_valid=1, Dir=5 stable; after release dir=5 commits, then req1 the next cycle.
5. Zero discard: req0 dir=0, data=0xFF -> req_ready[0]=1, RegEn stays 0, ptr advances so req1 is granted next; with ZERO_DISCARD=0 -> RegEn=1, Dir=0.
6. Saturation: CW=2 with both requesters valid for 6 cycles -> conflicts reads 1,2,3,3,3,3.
